// File: rtl/sync_fifo_flags_if.sv
// sync_fifo_flags_if: producer/consumer bundle for sync_fifo_flags.
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    logic                          flush;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          rd_en;
    logic [DATA_WIDTH-1:0]         rd_data;
    logic                          rd_valid;
    logic                          full;
    logic                          empty;
    logic                          almost_full;
    logic                          almost_empty;
    logic [$clog2(DEPTH+1)-1:0]    count;
    logic                          overflow;
    logic                          underflow;
    logic                          clr_err;

    modport master (
        output flush, wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input  flush, wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, threshold flags,
// sticky error flags, flush and selectable show-ahead or registered read.
module sync_fifo_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 14,
    parameter int AEMPTY_THRESH = 2,
    parameter bit FWFT          = 1'b1
) (
    input logic              clk,
    input logic              reset_n,
    sync_fifo_flags_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_ovf;
    logic                  r_udf;

    logic          w_full;
    logic          w_empty;
    logic          w_rd_acc;
    logic          w_wr_acc;
    logic          w_ovf_set;
    logic          w_udf_set;
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [PW-1:0] w_rd_ptr_nxt;

    // flush suppresses both acceptances so the pointer/count logic only sees real traffic
    assign w_full       = r_count == CW'(DEPTH);
    assign w_empty      = r_count == '0;
    assign w_rd_acc     = bus.rd_en && !w_empty && !bus.flush;
    assign w_wr_acc     = bus.wr_en && (!w_full || w_rd_acc) && !bus.flush;
    assign w_ovf_set    = bus.wr_en && w_full && !w_rd_acc && !bus.flush;
    assign w_udf_set    = bus.rd_en && w_empty && !bus.flush;
    assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk)
        if (w_wr_acc) r_mem[r_wr_ptr] <= bus.wr_data;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= w_wr_ptr_nxt;
            if (w_rd_acc) r_rd_ptr <= w_rd_ptr_nxt;
            if (w_wr_acc != w_rd_acc) r_count <= w_wr_acc ? r_count + 1'b1 : r_count - 1'b1;
            if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
            r_rd_valid <= w_rd_acc;
        end

    // a new error in the same cycle as clr_err wins
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf && !bus.clr_err) || w_ovf_set;
            r_udf <= (r_udf && !bus.clr_err) || w_udf_set;
        end

    assign bus.rd_data      = FWFT ? r_mem[r_rd_ptr] : r_rd_data;
    assign bus.rd_valid     = FWFT ? !w_empty : r_rd_valid;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = r_count >= CW'(AFULL_THRESH);
    assign bus.almost_empty = r_count <= CW'(AEMPTY_THRESH);
    assign bus.count        = r_count;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_udf;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed checks of a 16-deep show-ahead FIFO and a
// 5-deep registered-read FIFO sharing one clock and reset.
module tb_sync_fifo_flags;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(16)) a_if ();
    sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(5))  b_if ();

    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1'b1))
        u_a (.clk(clk), .reset_n(reset_n), .bus(a_if.slave));
    sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1), .FWFT(1'b0))
        u_b (.clk(clk), .reset_n(reset_n), .bus(b_if.slave));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        a_if.flush = 0; a_if.wr_en = 0; a_if.rd_en = 0; a_if.clr_err = 0; a_if.wr_data = 0;
        b_if.flush = 0; b_if.wr_en = 0; b_if.rd_en = 0; b_if.clr_err = 0; b_if.wr_data = 0;
    endtask

    task automatic test_reset;
        idle();
        reset_n = 0;
        #12;
        checks++;
        if (a_if.count !== 5'd0 || a_if.empty !== 1'b1 || a_if.almost_empty !== 1'b1 || a_if.full !== 1'b0 ||
            a_if.almost_full !== 1'b0 || a_if.overflow !== 1'b0 || a_if.underflow !== 1'b0 || a_if.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_a: count=%0d empty=%b ae=%b full=%b af=%b ovf=%b udf=%b rv=%b, want 0 1 1 0 0 0 0 0",
                a_if.count, a_if.empty, a_if.almost_empty, a_if.full, a_if.almost_full, a_if.overflow, a_if.underflow, a_if.rd_valid);
        end
        checks++;
        if (b_if.rd_data !== 8'h00 || b_if.rd_valid !== 1'b0 || b_if.count !== 3'd0) begin
            failures++;
            $display("FAIL reset_b: rd_data=%h rv=%b count=%0d, want 00 0 0", b_if.rd_data, b_if.rd_valid, b_if.count);
        end
        @(negedge clk);
        reset_n = 1;
        tick();
    endtask

    task automatic test_fill_drain;
        for (int i = 0; i < 16; i++) begin
            a_if.wr_en = 1; a_if.wr_data = 8'(i);
            tick();
            checks++;
            if (a_if.count !== 5'(i + 1) || a_if.almost_full !== (i + 1 >= 14) || a_if.full !== (i == 15) || a_if.empty !== 1'b0) begin
                failures++;
                $display("FAIL fill[%0d]: count=%0d af=%b full=%b empty=%b, want %0d %b %b 0",
                    i, a_if.count, a_if.almost_full, a_if.full, a_if.empty, i + 1, i + 1 >= 14, i == 15);
            end
        end
        a_if.wr_en = 0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (a_if.rd_data !== 8'(i) || a_if.rd_valid !== 1'b1) begin
                failures++;
                $display("FAIL drain[%0d]: rd_data=%h rv=%b, want %h 1", i, a_if.rd_data, a_if.rd_valid, 8'(i));
            end
            a_if.rd_en = 1;
            tick();
        end
        a_if.rd_en = 0;
        checks++;
        if (a_if.empty !== 1'b1 || a_if.count !== 5'd0 || a_if.rd_valid !== 1'b0 || a_if.almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL drained: empty=%b count=%0d rv=%b ae=%b, want 1 0 0 1", a_if.empty, a_if.count, a_if.rd_valid, a_if.almost_empty);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 16; i++) begin
            a_if.wr_en = 1; a_if.wr_data = 8'(8'h10 + i);
            tick();
        end
        a_if.wr_data = 8'hAA;
        tick();
        a_if.wr_en = 0;
        checks++;
        if (a_if.overflow !== 1'b1 || a_if.count !== 5'd16 || a_if.rd_data !== 8'h10) begin
            failures++;
            $display("FAIL overflow: ovf=%b count=%0d head=%h, want 1 16 10", a_if.overflow, a_if.count, a_if.rd_data);
        end
        a_if.clr_err = 1;
        tick();
        a_if.clr_err = 0;
        checks++;
        if (a_if.overflow !== 1'b0) begin
            failures++;
            $display("FAIL clr_err: ovf=%b, want 0", a_if.overflow);
        end
    endtask

    task automatic test_full_rw;
        a_if.rd_en = 1; a_if.wr_en = 1; a_if.wr_data = 8'h55;
        tick();
        a_if.rd_en = 0; a_if.wr_en = 0;
        checks++;
        if (a_if.count !== 5'd16 || a_if.rd_data !== 8'h11 || a_if.overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_rw: count=%0d head=%h ovf=%b, want 16 11 0", a_if.count, a_if.rd_data, a_if.overflow);
        end
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (a_if.rd_data !== ((j < 15) ? 8'(8'h11 + j) : 8'h55)) begin
                failures++;
                $display("FAIL full_rw_drain[%0d]: rd_data=%h, want %h", j, a_if.rd_data, (j < 15) ? 8'(8'h11 + j) : 8'h55);
            end
            a_if.rd_en = 1;
            tick();
        end
        a_if.rd_en = 0;
        checks++;
        if (a_if.empty !== 1'b1) begin
            failures++;
            $display("FAIL full_rw_empty: empty=%b, want 1", a_if.empty);
        end
    endtask

    task automatic test_empty_rw;
        a_if.rd_en = 1; a_if.wr_en = 1; a_if.wr_data = 8'h33;
        tick();
        a_if.rd_en = 0; a_if.wr_en = 0;
        checks++;
        if (a_if.underflow !== 1'b1 || a_if.count !== 5'd1 || a_if.rd_data !== 8'h33 || a_if.rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL empty_rw: udf=%b count=%0d rd_data=%h rv=%b, want 1 1 33 1",
                a_if.underflow, a_if.count, a_if.rd_data, a_if.rd_valid);
        end
    endtask

    task automatic test_wrap_registered;
        for (int k = 0; k <= 12; k++) begin
            b_if.wr_en = (k < 12); b_if.wr_data = 8'(8'hA0 + k);
            b_if.rd_en = (k >= 1);
            tick();
            checks++;
            if (b_if.rd_valid !== (k >= 1) || (k >= 1 && b_if.rd_data !== 8'(8'hA0 + k - 1)) || b_if.count !== ((k < 12) ? 3'd1 : 3'd0)) begin
                failures++;
                $display("FAIL wrap[%0d]: rv=%b rd_data=%h count=%0d, want %b %h %0d",
                    k, b_if.rd_valid, b_if.rd_data, b_if.count, k >= 1, 8'(8'hA0 + k - 1), (k < 12) ? 1 : 0);
            end
        end
        b_if.wr_en = 0; b_if.rd_en = 0;
        tick();
        checks++;
        if (b_if.rd_valid !== 1'b0 || b_if.rd_data !== 8'hAB || b_if.empty !== 1'b1) begin
            failures++;
            $display("FAIL wrap_hold: rv=%b rd_data=%h empty=%b, want 0 ab 1", b_if.rd_valid, b_if.rd_data, b_if.empty);
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) begin
            a_if.wr_en = 1; a_if.wr_data = 8'(8'hC0 + i);
            tick();
        end
        a_if.flush = 1;
        tick();
        a_if.flush = 0; a_if.wr_en = 0;
        checks++;
        if (a_if.count !== 5'd0 || a_if.empty !== 1'b1 || a_if.rd_valid !== 1'b0 || a_if.underflow !== 1'b1 || a_if.overflow !== 1'b0) begin
            failures++;
            $display("FAIL flush_a: count=%0d empty=%b rv=%b udf=%b ovf=%b, want 0 1 0 1 0",
                a_if.count, a_if.empty, a_if.rd_valid, a_if.underflow, a_if.overflow);
        end
        for (int i = 0; i < 2; i++) begin
            b_if.wr_en = 1; b_if.wr_data = 8'(8'hD0 + i);
            tick();
        end
        b_if.wr_en = 0; b_if.rd_en = 1;
        tick();
        b_if.flush = 1;
        tick();
        b_if.flush = 0; b_if.rd_en = 0;
        checks++;
        if (b_if.rd_valid !== 1'b0 || b_if.count !== 3'd0 || b_if.rd_data !== 8'hD0) begin
            failures++;
            $display("FAIL flush_b: rv=%b count=%0d rd_data=%h, want 0 0 d0", b_if.rd_valid, b_if.count, b_if.rd_data);
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 6; i++) begin
            a_if.wr_en = 1; a_if.wr_data = 8'(i);
            b_if.wr_en = 1; b_if.wr_data = 8'(i);
            b_if.rd_en = (i > 0);
            tick();
        end
        #2;
        reset_n = 0;
        #1;
        checks++;
        if (a_if.count !== 5'd0 || a_if.empty !== 1'b1 || a_if.almost_empty !== 1'b1 || a_if.full !== 1'b0 ||
            a_if.almost_full !== 1'b0 || a_if.underflow !== 1'b0 || a_if.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_a: count=%0d empty=%b ae=%b full=%b af=%b udf=%b rv=%b, want 0 1 1 0 0 0 0",
                a_if.count, a_if.empty, a_if.almost_empty, a_if.full, a_if.almost_full, a_if.underflow, a_if.rd_valid);
        end
        checks++;
        if (b_if.rd_data !== 8'h00 || b_if.rd_valid !== 1'b0 || b_if.count !== 3'd0) begin
            failures++;
            $display("FAIL async_reset_b: rd_data=%h rv=%b count=%0d, want 00 0 0", b_if.rd_data, b_if.rd_valid, b_if.count);
        end
        idle();
        @(negedge clk);
        reset_n = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_wrap_registered();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
